// File: rtl/key_debounce.sv
// key_debounce: front-panel key conditioner for the manual timing generator.
// Synchronises and debounces six momentary keys, accepts exactly one key per
// manual cycle, and holds key_start until the generator reports end of cycle.
// Optional feature: define KEY_REPEAT_EN to auto-repeat a held DEP or EXAM key.
// Key map: [0]START [1]LOAD_ADD [2]DEP [3]EXAM [4]CONT [5]STOP.
module key_debounce #(
    parameter int DEB_CYCLES    = 100000,
    parameter int DEB_W         = 17
`ifdef KEY_REPEAT_EN
    ,
    parameter int REPEAT_CYCLES = 10000000,
    parameter int RPT_W         = 24
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] key_raw,
    input  logic       mfts_busy,
    input  logic       mftp2,
    output logic [5:0] key_deb,
    output logic [5:0] key_sel,
    output logic       key_start,
    output logic       key_err
);

    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    logic [5:0]       sync1_q;
    logic [5:0]       sync_q;
    logic [5:0]       deb_q;
    logic [5:0]       deb_prev_q;
    logic [DEB_W-1:0] deb_cnt [6];

    state_t     state_q, state_d;
    logic [5:0] sel_q, sel_d;
    logic       start_q, start_d;
    logic       err_q, err_d;

    logic [5:0] rise;
    logic       multi;
    logic       single;

`ifdef KEY_REPEAT_EN
    localparam logic [RPT_W-1:0] RPT_MAX = RPT_W'(REPEAT_CYCLES - 1);
    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic             rpt_key;
`endif

    // Two-flop synchroniser for the asynchronous key inputs.
    // NOTE: non-blocking assignments make both flops sample the old values on the same edge; blocking here would collapse the chain to one flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync_q  <= '0;
        end else begin
            sync1_q <= key_raw;
            sync_q  <= sync1_q;
        end
    end

    // Per-key debounce: accept a new level only after it is stable for DEB_CYCLES clocks.
    // NOTE: the counter array is only a handful of flops, so it is reset like any other state rather than left as uninitialised memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_q <= '0;
            for (int i = 0; i < 6; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (sync_q[i] == deb_q[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_MAX) begin
                    deb_q[i]   <= sync_q[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Previous debounced level, used for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) deb_prev_q <= '0;
        else        deb_prev_q <= deb_q;
    end

    assign rise   = deb_q & ~deb_prev_q;
    assign multi  = |(deb_q & (deb_q - 6'd1));
    assign single = (deb_q != 6'd0) && !multi;

`ifdef KEY_REPEAT_EN
    // Only DEP and EXAM are allowed to auto-repeat.
    assign rpt_key = sel_q[2] | sel_q[3];
`endif

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            start_q <= 1'b0;
            err_q   <= 1'b0;
`ifdef KEY_REPEAT_EN
            rpt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            start_q <= start_d;
            err_q   <= err_d;
`ifdef KEY_REPEAT_EN
            rpt_q   <= rpt_d;
`endif
        end
    end

    // FSM next-state and next-output decisions.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves one unassigned, which would infer a latch.
        state_d = state_q;
        sel_d   = sel_q;
        start_d = start_q;
        err_d   = err_q;
`ifdef KEY_REPEAT_EN
        rpt_d   = '0;
`endif
        case (state_q)
            IDLE: begin
                if (multi) begin
                    err_d   = 1'b1;
                    state_d = ERR;
                end else if (single && (rise == deb_q) && !mfts_busy) begin
                    sel_d   = rise;
                    start_d = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                // Request stays up until the cycle completes, whatever the keys do.
                if (mftp2) begin
                    start_d = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (deb_q == 6'd0) begin
                    sel_d   = '0;
                    state_d = IDLE;
                end
`ifdef KEY_REPEAT_EN
                else if (rpt_key && (deb_q == sel_q)) begin
                    if (rpt_q == RPT_MAX) begin
                        start_d = 1'b1;
                        state_d = REQ;
                    end else begin
                        rpt_d = rpt_q + 1'b1;
                    end
                end
`endif
            end
            ERR: begin
                if (deb_q == 6'd0) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign key_deb   = deb_q;
    assign key_sel   = sel_q;
    assign key_start = start_q;
    assign key_err   = err_q;

endmodule
